// File: rtl/addsub_accumulator_pkg.sv
// Package for the add/subtract accumulator.
// Holds the per-operation field bundle and the saturation constant helpers
// shared by the accumulator top level.
package addsub_pkg;

    // Operation fields captured together on an accepted input.
    typedef struct packed {
        logic clear;  // operate against zero instead of the accumulator
        logic sub;    // subtract the operand instead of adding it
        logic sat;    // clamp on overflow instead of wrapping
    } op_t;

    // Most-positive two's-complement value (011..1) for a w-bit word.
    // Returned zero-extended in 64 bits; callers truncate to their width.
    function automatic logic [63:0] sat_max(input int unsigned w);
        logic [63:0] v;
        v = (64'd1 << (w - 32'd1)) - 64'd1;
        return v;
    endfunction

    // Most-negative two's-complement value (100..0) for a w-bit word.
    function automatic logic [63:0] sat_min(input int unsigned w);
        logic [63:0] v;
        v = 64'd1 << (w - 32'd1);
        return v;
    endfunction

endpackage

// File: rtl/addsub_accumulator_ovf_core.sv
// Combinational add/subtract core with signed overflow detection.
// Ports:
//   a   - first operand (accumulator side)
//   b   - second operand; inverted when sub=1
//   sub - 1 = a - b (invert b, carry-in 1), 0 = a + b
//   sum - WIDTH-bit result of the ripple chain
//   ovf - carry into the MSB XOR carry out of the MSB
module addsub_ovf_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    logic [WIDTH-1:0] b_x_s;

    // Conditional inversion; replication follows the datapath width.
    assign b_x_s = b ^ {WIDTH{sub}};

    // Each bit keeps its own carry nets so the chain is not a single
    // self-referencing vector.
    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_bit
        logic c_in_s;
        logic c_out_s;
        if (i == 0) begin : g_first
            assign c_in_s = sub;
        end else begin : g_rest
            assign c_in_s = g_bit[i-1].c_out_s;
        end
        assign sum[i]  = a[i] ^ b_x_s[i] ^ c_in_s;
        assign c_out_s = (a[i] & b_x_s[i]) | (c_in_s & (a[i] ^ b_x_s[i]));
    end

    assign ovf = g_bit[WIDTH-1].c_out_s ^ g_bit[WIDTH-1].c_in_s;

endmodule

// File: rtl/addsub_accumulator.sv
// Signed add/subtract accumulator with wrap/saturate overflow handling,
// sticky overflow flag and a saturating operation counter.
// Ports:
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   - input handshake (in_ready = !out_valid || out_ready)
//   in_data             - signed operand
//   in_sub, in_clear    - subtract select; restart from zero (also restarts count)
//   sat_mode            - saturate (1) or wrap (0) on overflow, taken on accept
//   out_valid/out_ready - output handshake, single result register
//   acc_out, ovf        - accumulator value and overflow of the last accept
//   ovf_sticky, ovf_clr - accumulated overflow flag and its clear
//   op_count            - saturating count of accepts since last clear
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sub,
    input  logic             in_clear,
    input  logic             sat_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc_out,
    output logic             ovf,
    output logic             ovf_sticky,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [WIDTH-1:0] SAT_MAX_C = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN_C = WIDTH'(sat_min(WIDTH));
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);

    logic [WIDTH-1:0] acc_r;
    logic             ovf_r;
    logic             ovf_sticky_r;
    logic [CNT_W-1:0] op_count_r;
    logic             out_valid_r;

    op_t              op_s;
    logic             in_ready_s;
    logic             accept_s;
    logic [WIDTH-1:0] base_s;
    logic [WIDTH-1:0] raw_s;
    logic             ov_s;
    logic [WIDTH-1:0] acc_next_s;
    logic [CNT_W-1:0] cnt_next_s;

    assign op_s       = '{clear: in_clear, sub: in_sub, sat: sat_mode};
    assign in_ready_s = !out_valid_r || out_ready;
    assign accept_s   = in_valid && in_ready_s;
    assign base_s     = op_s.clear ? {WIDTH{1'b0}} : acc_r;

    addsub_ovf_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a   (base_s),
        .b   (in_data),
        .sub (op_s.sub),
        .sum (raw_s),
        .ovf (ov_s)
    );

    // Saturation clamps toward the sign of the base operand: an overflow
    // can only move the result away from the base's side of zero.
    always_comb begin
        acc_next_s = raw_s;
        if (ov_s && op_s.sat) begin
            if (base_s[WIDTH-1]) begin
                acc_next_s = SAT_MIN_C;
            end else begin
                acc_next_s = SAT_MAX_C;
            end
        end else begin
            acc_next_s = raw_s;
        end
    end

    // Next operation count: restart at one on clear, otherwise saturate.
    always_comb begin
        cnt_next_s = op_count_r;
        if (op_s.clear) begin
            cnt_next_s = CNT_ONE_C;
        end else if (op_count_r == CNT_MAX_C) begin
            cnt_next_s = CNT_MAX_C;
        end else begin
            cnt_next_s = op_count_r + CNT_ONE_C;
        end
    end

    // Result register: accumulator, per-op overflow and counter load on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r      <= {WIDTH{1'b0}};
            ovf_r      <= 1'b0;
            op_count_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            acc_r      <= acc_next_s;
            ovf_r      <= ov_s;
            op_count_r <= cnt_next_s;
        end
    end

    // Output valid: set by an accept, dropped once downstream takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Sticky overflow: a new overflow takes priority over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_r <= 1'b0;
        end else if (accept_s && ov_s) begin
            ovf_sticky_r <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky_r <= 1'b0;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign acc_out    = acc_r;
    assign ovf        = ovf_r;
    assign ovf_sticky = ovf_sticky_r;
    assign op_count   = op_count_r;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Scoreboard bench for addsub_accumulator (WIDTH=8). A second instance with
// CNT_W=2 shares all inputs so counter saturation can be observed in the
// same run.
module tb_addsub_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_sub, in_clear, sat_mode, out_ready, ovf_clr;
    logic [7:0] in_data;
    logic       in_ready, out_valid, ovf, ovf_sticky;
    logic [7:0] acc_out, op_count;
    logic       in_ready2, out_valid2, ovf2, ovf_sticky2;
    logic [7:0] acc_out2;
    logic [1:0] op_count2;

    typedef struct packed {
        logic [7:0] acc;
        logic       ovf;
        logic       sticky;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    logic [7:0] m_acc;
    logic       m_sticky, m_valid;
    logic [7:0] m_cnt;
    logic [1:0] m_cnt2;

    always #5 clk = ~clk;

    addsub_accumulator #(.WIDTH(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sub(in_sub), .in_clear(in_clear),
        .sat_mode(sat_mode), .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .ovf(ovf), .ovf_sticky(ovf_sticky),
        .ovf_clr(ovf_clr), .op_count(op_count)
    );

    addsub_accumulator #(.WIDTH(8), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_sub(in_sub), .in_clear(in_clear),
        .sat_mode(sat_mode), .out_valid(out_valid2), .out_ready(out_ready),
        .acc_out(acc_out2), .ovf(ovf2), .ovf_sticky(ovf_sticky2),
        .ovf_clr(ovf_clr), .op_count(op_count2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each consumed result against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_output: got acc %0h expected none", acc_out);
            end else begin
                e = q.pop_front();
                chk("mon_acc", acc_out, e.acc);
                chk("mon_ovf", ovf, e.ovf);
                chk("mon_sticky", ovf_sticky, e.sticky);
                chk("mon_cnt", op_count, e.cnt);
                chk("mon_cnt2", op_count2, e.cnt2);
                chk("mon_acc2", acc_out2, e.acc);
            end
        end
    end

    task automatic model_reset();
        m_acc = 8'd0; m_sticky = 1'b0; m_valid = 1'b0;
        m_cnt = 8'd0; m_cnt2 = 2'd0;
        q.delete();
    endtask

    // One clock cycle of stimulus; entered and left at posedge+1.
    task automatic cyc(input logic v, input logic [7:0] d, input logic sub,
                       input logic clr, input logic sat, input logic ordy,
                       input logic oclr);
        logic rdy_m, acc_m, ov, old_valid;
        int   b_i, d_i, r_i;
        logic [7:0] res;
        exp_t e;
        in_valid = v; in_data = d; in_sub = sub; in_clear = clr;
        sat_mode = sat; out_ready = ordy; ovf_clr = oclr;
        old_valid = m_valid;
        rdy_m = !m_valid || ordy;
        acc_m = v && rdy_m;
        if (acc_m) begin
            b_i = clr ? 0 : int'($signed(m_acc));
            d_i = int'($signed(d));
            r_i = sub ? b_i - d_i : b_i + d_i;
            ov  = (r_i > 127) || (r_i < -128);
            if (ov && sat) res = (b_i < 0) ? 8'h80 : 8'h7F;
            else           res = r_i[7:0];
            m_acc = res;
            if (ov) m_sticky = 1'b1;
            else if (oclr) m_sticky = 1'b0;
            m_cnt  = clr ? 8'd1 : ((m_cnt == 8'hFF) ? m_cnt : m_cnt + 8'd1);
            m_cnt2 = clr ? 2'd1 : ((m_cnt2 == 2'd3) ? m_cnt2 : m_cnt2 + 2'd1);
            e = '{res, ov, m_sticky, m_cnt, m_cnt2};
            q.push_back(e);
            m_valid = 1'b1;
        end else begin
            if (oclr) m_sticky = 1'b0;
            if (ordy) m_valid = 1'b0;
        end
        @(negedge clk);
        chk("in_ready", in_ready, rdy_m);
        chk("out_valid", out_valid, old_valid);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0; in_sub = 1'b0;
        in_clear = 1'b0; sat_mode = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_acc", acc_out, 8'd0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_sticky", ovf_sticky, 1'b0);
        chk("rst_cnt", op_count, 8'd0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Wrap: 100 + 27 = 127, then +1 wraps to -128.
        cyc(1'b1, 8'd100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 8'd27,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("wrap_127", acc_out, 8'h7F);
        chk("wrap_127_ovf", ovf, 1'b0);
        cyc(1'b1, 8'd1,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("wrap_m128", acc_out, 8'h80);
        chk("wrap_ovf", ovf, 1'b1);
        chk("wrap_sticky", ovf_sticky, 1'b1);
        chk("wrap_cnt", op_count, 8'd3);

        // Saturate: 120 + 50 -> 127; -100 - 100 -> -128.
        cyc(1'b1, 8'd120, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 8'd50,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("sat_pos", acc_out, 8'h7F);
        chk("sat_pos_ovf", ovf, 1'b1);
        cyc(1'b1, 8'h9C,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 8'd100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("sat_neg", acc_out, 8'h80);
        chk("sat_neg_ovf", ovf, 1'b1);

        // 0 - (-128): wraps to -128, saturates to +127.
        cyc(1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("negmin_wrap", acc_out, 8'h80);
        chk("negmin_wrap_ovf", ovf, 1'b1);
        cyc(1'b1, 8'h80, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("negmin_sat", acc_out, 8'h7F);
        chk("negmin_sat_ovf", ovf, 1'b1);
        idle();

        // Backpressure: accept, stall three cycles, then stream four.
        cyc(1'b1, 8'd10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'd20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_frozen", acc_out, 8'd10);
        chk("bp_cnt", op_count, 8'd1);
        cyc(1'b1, 8'd20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp_stream", acc_out, 8'd36);
        chk("bp_stream_cnt", op_count, 8'd5);
        idle();

        // Sticky: clear alone, then overflow coincident with clear, then clear.
        cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("sticky_clr", ovf_sticky, 1'b0);
        cyc(1'b1, 8'd100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 8'd100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("sticky_set_wins", ovf_sticky, 1'b1);
        chk("sticky_wrap_val", acc_out, 8'hC8);
        cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("sticky_clr2", ovf_sticky, 1'b0);

        // Counter saturation on the CNT_W=2 instance.
        cyc(1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("cnt2_sat", op_count2, 2'd3);
        chk("cnt8_five", op_count, 8'd5);
        idle();

        // Async reset with a result pending.
        cyc(1'b1, 8'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("arst_acc", acc_out, 8'd0);
        chk("arst_ovf", ovf, 1'b0);
        chk("arst_sticky", ovf_sticky, 1'b0);
        chk("arst_cnt", op_count, 8'd0);
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_ready", in_ready, 1'b1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("post_rst_acc", acc_out, 8'd5);
        chk("post_rst_cnt", op_count, 8'd1);
        idle();
        idle();

        chk("queue_empty", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/addsub_accumulator.md
Name: addsub_accumulator

Overview:
- Signed two's-complement accumulator built on an add/subtract datapath: each accepted input is added to, or subtracted from, a running sum.
- Per-operation overflow detection (carry-into-MSB XOR carry-out-of-MSB), selectable wrap/saturate mode, sticky overflow flag and an operation counter.
- Valid/ready handshakes on input and output; sits between a sample source and downstream DSP/statistics logic.

Parameters:
- WIDTH, 8, data and accumulator width in bits (>=2).
- CNT_W, 8, operation counter width in bits (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input operation valid.
- in_ready  output  1  block can accept an operation this cycle.
- in_data  input  WIDTH  signed operand.
- in_sub  input  1  1 = subtract in_data, 0 = add.
- in_clear  input  1  1 = operate against 0 instead of the accumulator (restart); also resets the counter.
- sat_mode  input  1  1 = saturate on overflow, 0 = wrap; sampled on accept.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- acc_out  output  WIDTH  signed accumulator value after the last accepted operation.
- ovf  output  1  last accepted operation overflowed.
- ovf_sticky  output  1  any overflow since reset or the last ovf_clr.
- ovf_clr  input  1  clears ovf_sticky.
- op_count  output  CNT_W  operations since the last clear, saturating.

Behaviour:
- Reset (async, rst_n=0): acc_out=0, ovf=0, ovf_sticky=0, op_count=0, out_valid=0. in_ready is combinational and reads 1 while out_valid=0. Deassertion is synchronised externally.
- Handshake:
  - in_ready = !out_valid || out_ready (single-stage register, full throughput).
  - Accept occurs when in_valid && in_ready.
  - out_valid rises the cycle after an accept; results hold stable while out_valid && !out_ready.
  - Accept and output consume can occur in the same cycle; no bubble.
- Arithmetic on accept:
  - base = in_clear ? 0 : acc.
  - b' = in_data XOR {WIDTH{in_sub}}, carry-in = in_sub.
  - raw = base + b' + cin over a WIDTH-bit carry chain.
  - ov = c[WIDTH] ^ c[WIDTH-1].
- Result selection:
  - If !ov, acc <= raw.
  - If ov and sat_mode=1, acc <= base[MSB] ? most-negative (100..0) : most-positive (011..1).
  - If ov and sat_mode=0, acc <= raw (wrap).
- Flags on accept:
  - ovf <= ov.
  - ovf_sticky <= ovf_sticky | ov.
  - ovf_clr in the same cycle as an overflowing accept leaves the sticky flag at 1 (set wins).
  - ovf_clr alone clears it on the next edge, regardless of out_valid.
- Counter on accept:
  - op_count <= in_clear ? 1 : op_count + 1.
  - Saturates at 2^CNT_W-1 (no wrap).
- Edge cases:
  - Subtracting most-negative from 0 overflows (0 - (-2^(W-1))). With sat_mode=1 the result is most-positive, because base sign=0.
  - in_clear with in_sub=1 yields the negated operand, with overflow semantics as above.
- No accept means no state change (except ovf_clr).
- Reset mid-transaction drops any pending result; out_valid=0 immediately.

Decomposition:
- Package addsub_pkg:
  - function sat_max(WIDTH) and sat_min(WIDTH) constants.
  - typedef for the op fields {clear, sub, sat}.
- Sub-module addsub_ovf_core, combinational, parameter WIDTH:
  - Inputs a, b, sub.
  - Outputs sum and ovf.
  - Structure: generate-loop ripple of per-bit adders with b XOR replicated sub. The replication width must be WIDTH, not a fixed literal.
- The top level holds the registers, handshake, saturation mux, sticky logic and counter.

Test Plan:
- WIDTH=8, wrap: clear+add 100, then add 27 -> acc_out=127, ovf=0; add 1 -> acc_out=-128, ovf=1, ovf_sticky=1, op_count=3.
- sat_mode=1: clear+add 120, add 50 -> acc_out=127, ovf=1. Then clear+add -100, sub 100 -> acc_out=-128, ovf=1.
- clear, sub -128 (from 0): wrap -> acc_out=-128, ovf=1; sat -> acc_out=127, ovf=1.
- Backpressure: out_ready=0 with in_valid=1 held -> in_ready=0 after the first accept, acc_out frozen. out_ready=1 for 4 cycles -> one accept per cycle, no drop/duplicate, checked against a reference model.
- Sticky: overflowing accept coincident with ovf_clr -> ovf_sticky=1. Next cycle ovf_clr alone -> 0. CNT_W=2: 5 accepts -> op_count stuck at 3.
- Async reset asserted mid-stream with out_valid=1 -> all outputs 0 immediately, no clock required. After release, the first accept computes from acc=0.
